// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: DVP 8-bit parallel-camera frame source, RGB565 pixels sent high byte first.
// Latency: every output except dvp_pclk is registered. With DVP_PATTERN_TX_EXT_PIXEL_EN defined,
//   pixels are fetched from pix_data; otherwise they come from the internal colour bars.
// Backpressure: none. The external pixel port is strobed two cycles before each pixel is needed.
module dvp_pattern_tx #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int H_BLANK  = 64,
  parameter int VS_LEN   = 16,
  parameter int VB_LEN   = 32,
  parameter int VF_LEN   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        dvp_pclk,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        pix_req,
  input  logic [15:0] pix_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int BYTES  = 2 * H_ACTIVE;
  localparam int M1     = (BYTES > VS_LEN) ? BYTES : VS_LEN;
  localparam int M2     = (M1 > VB_LEN) ? M1 : VB_LEN;
  localparam int M3     = (M2 > H_BLANK) ? M2 : H_BLANK;
  localparam int MAXLEN = (M3 > VF_LEN) ? M3 : VF_LEN;
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam int LW     = $clog2(V_ACTIVE + 1);

  localparam logic [CW-1:0] VS_LAST  = CW'(VS_LEN - 1);
  localparam logic [CW-1:0] VB_LAST  = CW'(VB_LEN - 1);
  localparam logic [CW-1:0] VB_PRE   = CW'(VB_LEN - 2);
  localparam logic [CW-1:0] ACT_LAST = CW'(BYTES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(BYTES - 4);
  localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] HB_PRE   = CW'(H_BLANK - 2);
  localparam logic [CW-1:0] VF_LAST  = CW'(VF_LEN - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

  state_t        state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [LW-1:0] line, nline;
  logic          last_vf;
  logic          req_nxt;
  logic [7:0]    data_nxt;

  // The pixel clock is inverted so each byte is centred on the dvp_pclk rising edge
  assign dvp_pclk = ~clk;

  // Next state and in-state counter; outputs are registered from these so that
  // a new vsync/href level coincides with the first cycle of its state
  always_comb begin
    nstate  = state;
    ncnt    = cnt + 1'b1;
    nline   = line;
    last_vf = 1'b0;
    case (state)
      IDLE: begin
        ncnt = '0;
        if (enable) nstate = VSYNC;
      end
      VSYNC: if (cnt == VS_LAST) begin
        nstate = VBACK;
        ncnt   = '0;
      end
      VBACK: if (cnt == VB_LAST) begin
        nstate = ACTIVE;
        ncnt   = '0;
      end
      ACTIVE: if (cnt == ACT_LAST) begin
        nstate = HBLANK;
        ncnt   = '0;
      end
      HBLANK: if (cnt == HB_LAST) begin
        ncnt = '0;
        if (line == LINE_LAST) begin
          nstate = VFRONT;
          nline  = '0;
        end else begin
          nstate = ACTIVE;
          nline  = line + 1'b1;
        end
      end
      VFRONT: if (cnt == VF_LAST) begin
        ncnt    = '0;
        last_vf = 1'b1;
        nstate  = enable ? VSYNC : IDLE;
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
  end

`ifdef DVP_PATTERN_TX_EXT_PIXEL_EN
  logic [7:0] pix_lo;

  // Request a pixel two cycles ahead of each even byte; the first request of a
  // line falls in the second-to-last cycle of VBACK or of a non-final HBLANK
  assign req_nxt = ((nstate == ACTIVE) && !ncnt[0] && (ncnt <= REQ_LAST)) ||
                   ((nstate == VBACK) && (ncnt == VB_PRE)) ||
                   ((nstate == HBLANK) && (ncnt == HB_PRE) && (line != LINE_LAST));

  // High byte comes straight from the port on capture; the low byte is held one cycle
  always_comb begin
    data_nxt = 8'h00;
    if (nstate == ACTIVE) data_nxt = ncnt[0] ? pix_lo : pix_data[15:8];
  end

  // Hold the low byte of the pixel captured on the even-byte edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_lo <= '0;
    else if ((nstate == ACTIVE) && !ncnt[0]) pix_lo <= pix_data[7:0];
  end
`else
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BSW   = $clog2(BAR_W + 1);
  localparam int XW    = $clog2(H_ACTIVE + 1);
  localparam logic [BSW-1:0] BS_LAST = BSW'(BAR_W - 1);
  localparam logic [XW-1:0]  X_LAST  = XW'(H_ACTIVE - 1);

  logic [2:0]     bar;
  logic [BSW-1:0] bar_sub;
  logic [XW-1:0]  px_x;
  logic [15:0]    bar_rgb;
  logic           pix_data_unused;

  assign pix_data_unused = ^pix_data;
  assign req_nxt         = 1'b0;

  // Colour of the current bar
  always_comb begin
    case (bar)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  // Select high or low byte of the bar colour for the byte about to be driven
  always_comb begin
    data_nxt = 8'h00;
    if (nstate == ACTIVE) data_nxt = ncnt[0] ? bar_rgb[7:0] : bar_rgb[15:8];
  end

  // Step the pattern position once per pixel, after its low byte is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_x    <= '0;
      bar_sub <= '0;
      bar     <= '0;
    end else if ((nstate == ACTIVE) && ncnt[0]) begin
      if (px_x == X_LAST) begin
        px_x    <= '0;
        bar_sub <= '0;
        bar     <= '0;
      end else begin
        px_x <= px_x + 1'b1;
        if (bar_sub == BS_LAST) begin
          bar_sub <= '0;
          bar     <= bar + 1'b1;
        end else begin
          bar_sub <= bar_sub + 1'b1;
        end
      end
    end
  end
`endif

  // Frame FSM state and all registered DVP outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      line       <= '0;
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_data   <= 8'h00;
      pix_req    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      line       <= nline;
      dvp_vsync  <= (nstate == VSYNC);
      dvp_href   <= (nstate == ACTIVE);
      dvp_data   <= data_nxt;
      pix_req    <= req_nxt;
      busy       <= (nstate != IDLE);
      frame_done <= last_vf;
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
module tb_dvp_pattern_tx;
  localparam int H = 8, V = 2, HB = 4, VS = 3, VB = 4, VF = 4;
  localparam int FRAME_LEN  = 51;
  localparam int LINE_BYTES = 16;
`ifdef DVP_PATTERN_TX_EXT_PIXEL_EN
  localparam int EXP_REQ = 16;
`else
  localparam int EXP_REQ = 0;
  logic [7:0] bar_line [LINE_BYTES] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                        8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic        dvp_pclk, dvp_vsync, dvp_href, pix_req, busy, frame_done;
  logic [7:0]  dvp_data;
  logic [15:0] pix_data;

  int total = 0, bad = 0;
  int cyc = 0;
  int fd_count = 0;
  int stim_n = 0;
  int fifo_n;

  logic [7:0] exp_bytes [$];
  int         exp_len   [$];
  bit         exp_after [$];

  dvp_pattern_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VS_LEN(VS), .VB_LEN(VB), .VF_LEN(VF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dvp_pclk(dvp_pclk), .dvp_vsync(dvp_vsync),
    .dvp_href(dvp_href), .dvp_data(dvp_data), .pix_req(pix_req), .pix_data(pix_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data valid the cycle after a read strobe, values 0x1234 + n
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_n   <= 0;
      pix_data <= 16'h0000;
    end else if (pix_req) begin
      pix_data <= 16'(16'h1234 + fifo_n);
      fifo_n   <= fifo_n + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue the expected bytes and frame-end behaviour of one full frame
  task automatic push_frame(input bit vs_after);
    logic [15:0] pix;
    pix = 16'h0000;
    for (int l = 0; l < V; l++) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
`ifdef DVP_PATTERN_TX_EXT_PIXEL_EN
        if (b % 2 == 0) begin
          pix = 16'(16'h1234 + stim_n);
          exp_bytes.push_back(pix[15:8]);
        end else begin
          exp_bytes.push_back(pix[7:0]);
          stim_n++;
        end
`else
        exp_bytes.push_back(bar_line[b]);
`endif
      end
    end
    exp_len.push_back(FRAME_LEN);
    exp_after.push_back(vs_after);
  endtask

  // Monitor / scoreboard
  int vs_start = 0, href_cnt = 0, req_cnt = 0, byte_idx = 0;
  bit in_frame = 0, prev_vs = 0;
  int req_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; prev_vs = 0; byte_idx = 0; req_cnt = 0; href_cnt = 0;
      req_q.delete();
    end else begin
      if (frame_done) begin
        if (exp_len.size() == 0) check("frame_done_unexpected", 1, 0);
        else begin
          check("frame_len", cyc - vs_start, exp_len.pop_front());
          begin
            bit ea;
            ea = exp_after.pop_front();
            check("vsync_at_done", dvp_vsync, ea);
            check("busy_at_done", busy, ea);
          end
          check("pix_req_count", req_cnt, EXP_REQ);
          check("href_cycles", href_cnt, 2 * H * V);
          check("req_leftover", req_q.size(), 0);
        end
        fd_count++;
        in_frame = 0;
      end
      if (dvp_vsync && !prev_vs) begin
        vs_start = cyc; in_frame = 1; req_cnt = 0; href_cnt = 0;
      end
      if (!dvp_vsync && prev_vs) check("vsync_len", cyc - vs_start, VS);
      prev_vs = dvp_vsync;
      if (pix_req) begin
        req_cnt++;
        req_q.push_back(cyc);
      end
      if (dvp_href) begin
        if (!in_frame) check("href_outside_frame", 1, 0);
        href_cnt++;
        if (exp_bytes.size() == 0) check("byte_unexpected", dvp_data, 0);
        else check("dvp_byte", dvp_data, exp_bytes.pop_front());
`ifdef DVP_PATTERN_TX_EXT_PIXEL_EN
        if (byte_idx % 2 == 0) begin
          if (req_q.size() == 0) check("pix_req_missing", 1, 0);
          else check("pix_req_lead", cyc - req_q.pop_front(), 2);
        end
`endif
        byte_idx++;
      end else begin
        byte_idx = 0;
        check("idle_data", dvp_data, 8'h00);
      end
    end
  end

  task automatic wait_fd(input int target);
    int n;
    n = 0;
    while (fd_count < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_timeout", fd_count >= target, 1);
  endtask

  task automatic wait_href();
    int n;
    n = 0;
    while (!dvp_href && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("href_timeout", dvp_href, 1);
  endtask

  initial begin
    bit seen;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vsync", dvp_vsync, 0);
    check("rst_href", dvp_href, 0);
    check("rst_data", dvp_data, 0);
    check("rst_pix_req", pix_req, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);

    // Two back-to-back frames, then a third during which enable drops
    push_frame(1'b1);
    push_frame(1'b1);
    push_frame(1'b0);
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_fd(2);
    wait_href();
    enable = 1'b0;
    wait_fd(3);

    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dvp_vsync || busy) seen = 1;
    end
    check("stays_idle", seen, 0);

    // Asynchronous reset in the middle of a line
    push_frame(1'b1);
    @(negedge clk);
    enable = 1'b1;
    wait_href();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {dvp_vsync, dvp_href, dvp_data, pix_req, busy, frame_done}, 0);
    exp_bytes.delete();
    exp_len.delete();
    exp_after.delete();
    stim_n = 0;
    push_frame(1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int target;
      target = fd_count + 1;
      wait_href();
      enable = 1'b0;
      wait_fd(target);
    end
    repeat (10) @(negedge clk);
    check("queues_drained", exp_bytes.size() + exp_len.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
